graphic_line_scheduler: RTL and testbench
=========================================

// Module: graphic_line_scheduler
// PURPOSE
//  Ping-pong line-buffer scheduler for the OSD graphic generator. It sequences rendering of line y+1
//  into one bank while line y streams out of the other bank on AXI-Stream. It issues render_start/
//  render_y to the instruction FSM, accepts its pixel writes, swaps banks and generates tuser/tlast.
// PARAMETERS
//  ACTIVE_HORI  320  pixels per line (stream beats per line)
//  ACTIVE_VERT  240  lines per frame
//  XW           12   pixel x / line y width
//  DW           16   pixel width (RGB565)
// PORTS
//  hclk          in   1   clock
//  hreset        in   1   asynchronous reset, active-high
//  en            in   1   scheduler enable (level)
//  init_done     out  1   bank clear after reset finished
//  render_start  out  1   one-cycle pulse: begin rendering line render_y
//  render_y      out  XW  line being rendered, stable from render_start until render_done
//  render_done   in   1   renderer finished current line (pulse)
//  wr_en         in   1   pixel write strobe
//  wr_x          in   XW  pixel write x
//  wr_d          in   DW  pixel write data
//  tdata_m       out  DW  stream pixel
//  tvalid_m      out  1   stream valid
//  tlast_m       out  1   last pixel of line
//  tuser_m       out  1   first pixel of frame
//  tready_m      in   1   stream ready
//  frame_cnt     out  16  completed frames, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0, both FSMs in their first state; fill_bank=0, y counters=0.
//  Banks: two ACTIVE_HORI x DW RAMs, 1-cycle read latency. Role per bank: fill or stream.
//  Render FSM:
//   R_CLEAR: write 0 to address 0..ACTIVE_HORI-1 of both banks (ACTIVE_HORI cycles), then
//            init_done=1 and go to R_IDLE. en is ignored during R_CLEAR.
//   R_IDLE: if en -> R_START; render_y=0, stream_y=0 on entry from idle.
//   R_START: render_start=1 for exactly one cycle -> R_BUSY.
//   R_BUSY: wr_en && wr_x<ACTIVE_HORI writes wr_d to fill bank; wr_x>=ACTIVE_HORI is dropped.
//           render_done -> R_FULL.
//   R_FULL: wait until stream FSM is in S_IDLE; then swap banks (fill_bank toggles), stream
//           line = render_y, render_y increments (ACTIVE_VERT-1 wraps to 0), -> R_START if en,
//           else -> R_IDLE.
//   wr_en and render_done outside R_BUSY are ignored.
//  Stream FSM:
//   S_IDLE: on swap -> S_PRIME (issue read addr 0).
//   S_PRIME: load tdata_m; tvalid_m=1 next cycle -> S_STREAM. Swap to first tvalid_m = 2 cycles.
//   S_STREAM: beat accepted on tvalid_m&&tready_m; tdata_m holds stable while tready_m=0.
//     Next pixel is prefetched so back-to-back beats sustain 1 pixel/cycle.
//     Read-and-clear: when a word is accepted, 0 is written to its address in the stream bank,
//     so every bank is all-zero (transparent background) when it returns to fill role.
//     tlast_m=1 on beat ACTIVE_HORI-1; tuser_m=1 on beat 0 when stream line==0.
//     Last beat accepted -> S_IDLE, tvalid_m=0 next cycle; if stream line==ACTIVE_VERT-1,
//     frame_cnt increments.
//  Simultaneous: render_done in the same cycle as the last beat is accepted -> swap occurs
//   next cycle (R_FULL sees S_IDLE). tvalid_m never drops mid-line.
//  en deassert: current render and stream line complete; no new render_start is issued.
//   Re-enable restarts at line 0 (tuser_m on the first line).
//  hreset mid-line: immediate return to reset state, tvalid_m=0, R_CLEAR reruns (RAMs are
//   recleared; no partial line is streamed).
// TESTING
//  Reset, en=1 -> init_done after 320 cycles; render_start pulse with render_y=0 one cycle after R_IDLE.
//  Write x=5 d=0xF800, render_done, tready=1 -> 320 beats, beat5=0xF800, others 0, tuser on beat0, tlast on beat319.
//  Render line1 during line0 stream; second line streams beat0 two cycles after line0 tlast; bank1 data correct.
//  tready toggled 1/0 every cycle -> tdata/tlast held while stalled; no loss/dup over 320 beats.
//  wr_x=320 and wr_en in R_IDLE -> no RAM change; line re-streamed later shows zeros (clear verified).
//  Run 240 lines -> render_y wraps to 0, frame_cnt=1, tuser on next line; hreset mid-line -> tvalid 0 async.

Source files
------------

// File: rtl/graphic_line_scheduler.sv
// Ping-pong line-buffer scheduler: renders line y+1 into the fill bank while
// line y streams out of the other bank on AXI-Stream with tuser/tlast framing.
`timescale 1ns/1ps
module graphic_line_scheduler #(
  parameter int unsigned ACTIVE_HORI = 320,
  parameter int unsigned ACTIVE_VERT = 240,
  parameter int unsigned XW          = 12,
  parameter int unsigned DW          = 16
) (
  input  logic          hclk,
  input  logic          hreset,
  input  logic          en,
  output logic          init_done,
  output logic          render_start,
  output logic [XW-1:0] render_y,
  input  logic          render_done,
  input  logic          wr_en,
  input  logic [XW-1:0] wr_x,
  input  logic [DW-1:0] wr_d,
  output logic [DW-1:0] tdata_m,
  output logic          tvalid_m,
  output logic          tlast_m,
  output logic          tuser_m,
  input  logic          tready_m,
  output logic [15:0]   frame_cnt
);

  localparam int unsigned AW        = $clog2(ACTIVE_HORI);
  localparam logic [AW-1:0] LAST_BEAT = AW'(ACTIVE_HORI - 1);
  localparam logic [AW-1:0] PEN_BEAT  = AW'(ACTIVE_HORI - 2);
  localparam logic [AW:0]   HORI_R    = (AW+1)'(ACTIVE_HORI);
  localparam logic [XW-1:0] HORI_X    = XW'(ACTIVE_HORI);
  localparam logic [XW-1:0] LAST_Y    = XW'(ACTIVE_VERT - 1);

  localparam logic [2:0] R_CLEAR  = 3'd0;
  localparam logic [2:0] R_IDLE   = 3'd1;
  localparam logic [2:0] R_START  = 3'd2;
  localparam logic [2:0] R_BUSY   = 3'd3;
  localparam logic [2:0] R_FULL   = 3'd4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PRIME  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [2:0]    r_state_q, r_state_d;
  logic [1:0]    s_state_q, s_state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          fill_bank_q, fill_bank_d;
  logic [XW-1:0] render_y_q, render_y_d;
  logic [XW-1:0] stream_y_q, stream_y_d;
  logic [AW-1:0] beat_q, beat_d;
  logic [AW:0]   rd_addr_q, rd_addr_d;
  logic [DW-1:0] tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic          tuser_q, tuser_d;
  logic          init_done_q, init_done_d;
  logic          render_start_q, render_start_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic [DW-1:0] bank0_q [ACTIVE_HORI];
  logic [DW-1:0] bank1_q [ACTIVE_HORI];
  logic [DW-1:0] rd_data_q;

  logic          swap_c, accept_c, rd_en_c, rd_bank_c;
  logic [AW:0]   rd_addr_c;
  logic          render_we_c, scrub_we_c;
  logic          we0_c, we1_c;
  logic [AW-1:0] wa0_c, wa1_c;
  logic [DW-1:0] wd0_c, wd1_c;

  assign accept_c  = tvalid_q && tready_m;
  // Reads target the bank about to become the stream bank while idle (swap cycle).
  assign rd_bank_c = (s_state_q == S_IDLE) ? fill_bank_q : ~fill_bank_q;

  // Next-state and output decode for the render and stream FSMs.
  always_comb begin
    r_state_d      = r_state_q;
    s_state_d      = s_state_q;
    clr_cnt_d      = clr_cnt_q;
    fill_bank_d    = fill_bank_q;
    render_y_d     = render_y_q;
    stream_y_d     = stream_y_q;
    beat_d         = beat_q;
    rd_addr_d      = rd_addr_q;
    tdata_d        = tdata_q;
    tvalid_d       = tvalid_q;
    tlast_d        = tlast_q;
    tuser_d        = tuser_q;
    init_done_d    = init_done_q;
    frame_cnt_d    = frame_cnt_q;
    render_start_d = 1'b0;
    swap_c         = 1'b0;
    rd_en_c        = 1'b0;
    rd_addr_c      = '0;

    case (r_state_q)
      R_CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == LAST_BEAT) begin
          clr_cnt_d   = '0;
          init_done_d = 1'b1;
          r_state_d   = R_IDLE;
        end
      end
      R_IDLE: begin
        if (en) begin
          render_y_d = '0;
          r_state_d  = R_START;
        end
      end
      R_START: r_state_d = R_BUSY;
      R_BUSY: begin
        if (render_done) r_state_d = R_FULL;
      end
      R_FULL: begin
        if (s_state_q == S_IDLE) begin
          swap_c      = 1'b1;
          fill_bank_d = ~fill_bank_q;
          stream_y_d  = render_y_q;
          render_y_d  = (render_y_q == LAST_Y) ? '0 : render_y_q + XW'(1);
          r_state_d   = en ? R_START : R_IDLE;
        end
      end
      default: r_state_d = R_CLEAR;
    endcase
    render_start_d = (r_state_d == R_START);

    case (s_state_q)
      S_IDLE: begin
        if (swap_c) begin
          rd_en_c   = 1'b1;
          rd_addr_c = '0;
          rd_addr_d = (AW+1)'(1);
          s_state_d = S_PRIME;
        end
      end
      S_PRIME: begin
        tdata_d   = rd_data_q;
        tvalid_d  = 1'b1;
        tlast_d   = 1'b0;
        tuser_d   = (stream_y_q == '0);
        beat_d    = '0;
        rd_en_c   = (rd_addr_q < HORI_R);
        rd_addr_c = rd_addr_q;
        rd_addr_d = rd_addr_q + (AW+1)'(1);
        s_state_d = S_STREAM;
      end
      S_STREAM: begin
        if (accept_c) begin
          if (beat_q == LAST_BEAT) begin
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
            tuser_d   = 1'b0;
            s_state_d = S_IDLE;
            if (stream_y_q == LAST_Y) frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            tdata_d   = rd_data_q;
            beat_d    = beat_q + AW'(1);
            tlast_d   = (beat_q == PEN_BEAT);
            tuser_d   = 1'b0;
            rd_en_c   = (rd_addr_q < HORI_R);
            rd_addr_c = rd_addr_q;
            rd_addr_d = rd_addr_q + (AW+1)'(1);
          end
        end
      end
      default: s_state_d = S_IDLE;
    endcase
  end

  // Bank write-port steering: clear both, render into fill, scrub accepted words in stream.
  always_comb begin
    render_we_c = (r_state_q == R_BUSY) && wr_en && (wr_x < HORI_X);
    scrub_we_c  = (s_state_q == S_STREAM) && accept_c;
    if (r_state_q == R_CLEAR) begin
      we0_c = 1'b1;
      we1_c = 1'b1;
      wa0_c = clr_cnt_q;
      wa1_c = clr_cnt_q;
      wd0_c = '0;
      wd1_c = '0;
    end else begin
      we0_c = (render_we_c && !fill_bank_q) || (scrub_we_c && fill_bank_q);
      we1_c = (render_we_c && fill_bank_q) || (scrub_we_c && !fill_bank_q);
      wa0_c = fill_bank_q ? beat_q : wr_x[AW-1:0];
      wa1_c = fill_bank_q ? wr_x[AW-1:0] : beat_q;
      wd0_c = fill_bank_q ? '0 : wr_d;
      wd1_c = fill_bank_q ? wr_d : '0;
    end
  end

  // Line-buffer RAMs with one-cycle registered read.
  always_ff @(posedge hclk) begin
    if (we0_c) bank0_q[wa0_c] <= wd0_c;
    if (we1_c) bank1_q[wa1_c] <= wd1_c;
    if (rd_en_c) rd_data_q <= rd_bank_c ? bank1_q[rd_addr_c[AW-1:0]] : bank0_q[rd_addr_c[AW-1:0]];
  end

  // State and output registers.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state_q      <= R_CLEAR;
      s_state_q      <= S_IDLE;
      clr_cnt_q      <= '0;
      fill_bank_q    <= 1'b0;
      render_y_q     <= '0;
      stream_y_q     <= '0;
      beat_q         <= '0;
      rd_addr_q      <= '0;
      tdata_q        <= '0;
      tvalid_q       <= 1'b0;
      tlast_q        <= 1'b0;
      tuser_q        <= 1'b0;
      init_done_q    <= 1'b0;
      render_start_q <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      r_state_q      <= r_state_d;
      s_state_q      <= s_state_d;
      clr_cnt_q      <= clr_cnt_d;
      fill_bank_q    <= fill_bank_d;
      render_y_q     <= render_y_d;
      stream_y_q     <= stream_y_d;
      beat_q         <= beat_d;
      rd_addr_q      <= rd_addr_d;
      tdata_q        <= tdata_d;
      tvalid_q       <= tvalid_d;
      tlast_q        <= tlast_d;
      tuser_q        <= tuser_d;
      init_done_q    <= init_done_d;
      render_start_q <= render_start_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  assign init_done    = init_done_q;
  assign render_start = render_start_q;
  assign render_y     = render_y_q;
  assign tdata_m      = tdata_q;
  assign tvalid_m     = tvalid_q;
  assign tlast_m      = tlast_q;
  assign tuser_m      = tuser_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_graphic_line_scheduler.sv
// Directed bench for graphic_line_scheduler: clear, render/stream pipeline,
// back-pressure, read-and-clear, frame wrap and asynchronous reset.
`timescale 1ns/1ps
module tb_graphic_line_scheduler;

  logic        hclk, hreset, en;
  logic        init_done, render_start, render_done;
  logic [11:0] render_y, wr_x;
  logic        wr_en;
  logic [15:0] wr_d, tdata_m, frame_cnt;
  logic        tvalid_m, tlast_m, tuser_m, tready_m;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  bit abort = 0;

  graphic_line_scheduler dut (
    .hclk(hclk), .hreset(hreset), .en(en), .init_done(init_done),
    .render_start(render_start), .render_y(render_y), .render_done(render_done),
    .wr_en(wr_en), .wr_x(wr_x), .wr_d(wr_d), .tdata_m(tdata_m), .tvalid_m(tvalid_m),
    .tlast_m(tlast_m), .tuser_m(tuser_m), .tready_m(tready_m), .frame_cnt(frame_cnt)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected pixel of line y at x: one marker pixel per line, plus x=319 on lines y%4==1.
  function automatic logic [15:0] exp_pix(input int y, input int x);
    if (x == (y * 3 + 5) % 320) return 16'hF800 ^ 16'(y);
    if (x == 319 && (y % 4) == 1) return 16'h1000 + 16'(y);
    return 16'h0000;
  endfunction

  task automatic write_px(input logic [11:0] x, input logic [15:0] d);
    wr_en = 1'b1; wr_x = x; wr_d = d;
    @(negedge hclk);
    wr_en = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int cnt = 0;
    while (!init_done && cnt < 1000) begin @(negedge hclk); cnt++; end
    check_eq(tag, 32'(cnt), 32'd320);
  endtask

  task automatic render_all();
    int cnt, y;
    for (int k = 0; k <= 240 && !abort; k++) begin
      y = k % 240;
      if (k == 0) en = 1'b1;
      cnt = 0;
      while (!render_start && cnt < 3000) begin @(negedge hclk); cnt++; end
      if (!render_start) begin
        check_eq("render_start_timeout", 32'(render_start), 32'd1);
        abort = 1;
        break;
      end
      if (k == 0) check_eq("first_start_latency", 32'(cnt), 32'd1);
      check_eq($sformatf("render_y_k%0d", k), 32'(render_y), 32'(y));
      @(negedge hclk);
      if (k == 0) check_eq("render_start_pulse", 32'(render_start), 32'd0);
      write_px(12'((y * 3 + 5) % 320), 16'hF800 ^ 16'(y));
      if ((y % 4) == 1) write_px(12'd319, 16'h1000 + 16'(y));
      if (k == 0) begin
        write_px(12'd320, 16'hFFFF);
        write_px(12'd515, 16'h5555);
      end
      render_done = 1'b1;
      @(negedge hclk);
      render_done = 1'b0;
    end
  endtask

  task automatic consume_line(input int k, input bit toggle);
    int y, b, cnt, derr, lerr, uerr, herr, verr;
    logic [15:0] pd;
    logic pl;
    bit stalled;
    y = k % 240; b = 0; cnt = 0;
    derr = 0; lerr = 0; uerr = 0; herr = 0; verr = 0;
    stalled = 0; pd = '0; pl = 1'b0;
    while (!tvalid_m && cnt < 3000) begin @(negedge hclk); cnt++; end
    if (!tvalid_m) begin
      check_eq($sformatf("tvalid_timeout_k%0d", k), 32'(tvalid_m), 32'd1);
      abort = 1;
      return;
    end
    if (k == 1) check_eq("line_gap_cycles", 32'(cyc - last_acc_cyc), 32'd3);
    while (b < 320 && cnt < 5000) begin
      if (!tvalid_m) verr++;
      else begin
        if (stalled && (tdata_m !== pd || tlast_m !== pl)) herr++;
        if (tdata_m !== exp_pix(y, b)) derr++;
        if (tlast_m !== (b == 319)) lerr++;
        if (tuser_m !== (b == 0 && y == 0)) uerr++;
        if (k == 0 && b == 5) check_eq("l0_beat5", 32'(tdata_m), 32'h0000F800);
        if (k == 0 && b == 0) check_eq("l0_tuser_beat0", 32'(tuser_m), 32'd1);
        if (k == 0 && b == 319) check_eq("l0_tlast_beat319", 32'(tlast_m), 32'd1);
      end
      tready_m = toggle ? ~tready_m : 1'b1;
      stalled = tvalid_m && !tready_m;
      pd = tdata_m;
      pl = tlast_m;
      if (tvalid_m && tready_m) begin
        b++;
        if (b == 320) last_acc_cyc = cyc;
      end
      @(negedge hclk);
      cnt++;
    end
    if (tvalid_m) verr++;
    check_eq($sformatf("beats_k%0d", k), 32'(b), 32'd320);
    check_eq($sformatf("data_errs_k%0d", k), 32'(derr), 32'd0);
    check_eq($sformatf("frame_flag_errs_k%0d", k), 32'(lerr + uerr), 32'd0);
    check_eq($sformatf("valid_errs_k%0d", k), 32'(verr), 32'd0);
    if (toggle) check_eq($sformatf("hold_errs_k%0d", k), 32'(herr), 32'd0);
    if (k == 0) check_eq("frame_cnt_line0", 32'(frame_cnt), 32'd0);
    if (k == 239) check_eq("frame_cnt_wrap", 32'(frame_cnt), 32'd1);
  endtask

  task automatic consume_all();
    for (int k = 0; k <= 240 && !abort; k++) consume_line(k, k == 2);
  endtask

  initial begin
    int cnt;
    hreset = 1'b1; en = 1'b0; render_done = 1'b0;
    wr_en = 1'b0; wr_x = '0; wr_d = '0; tready_m = 1'b1;
    @(negedge hclk);
    check_eq("rst_init_done", 32'(init_done), 32'd0);
    check_eq("rst_tvalid", 32'(tvalid_m), 32'd0);
    check_eq("rst_render_start", 32'(render_start), 32'd0);
    check_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check_eq("rst_render_y", 32'(render_y), 32'd0);
    @(negedge hclk);
    hreset = 1'b0;
    wait_init("init_done_latency");

    // Idle with en low: pixel write and render_done must be ignored.
    wr_en = 1'b1; wr_x = 12'd7; wr_d = 16'hABCD; render_done = 1'b1;
    @(negedge hclk);
    wr_en = 1'b0; render_done = 1'b0;
    repeat (3) @(negedge hclk);
    check_eq("idle_no_start", 32'(render_start), 32'd0);

    fork
      render_all();
      consume_all();
    join

    // One more empty line, then reset mid-line.
    render_done = 1'b1;
    @(negedge hclk);
    render_done = 1'b0;
    cnt = 0;
    while (!tvalid_m && cnt < 2000) begin @(negedge hclk); cnt++; end
    tready_m = 1'b1;
    repeat (10) @(negedge hclk);
    check_eq("tvalid_mid_line", 32'(tvalid_m), 32'd1);
    #2 hreset = 1'b1;
    #1 check_eq("tvalid_async_reset", 32'(tvalid_m), 32'd0);
    @(negedge hclk);
    check_eq("reset_init_done", 32'(init_done), 32'd0);
    check_eq("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    check_eq("reset_render_y", 32'(render_y), 32'd0);
    hreset = 1'b0;
    wait_init("reclear_latency");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
